// File: rtl/wb_pkg.sv
// Shared encodings for the two-master Wishbone SRAM arbiter: FSM states and master ids.
package wb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_BUSY  = S_BUSY,
        ST_DRAIN = S_DRAIN
    } state_e;

    typedef enum logic {
        MID_A = 1'b0,
        MID_B = 1'b1
    } mid_e;

endpackage

// File: rtl/wb_outstanding_ctr.sv
// Tracks issued-but-unacknowledged slave transfers; an ack with nothing outstanding is ignored.
module wb_outstanding_ctr #(
    parameter int MAXOUT = 4,
    parameter int CBITS  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CBITS-1:0] count_o,
    output logic             full_o,
    output logic             zero_o
);

    logic [CBITS-1:0] count_q, count_d;
    logic             dec_ok;

    always_comb begin
        dec_ok  = dec_i & (count_q != '0);
        count_d = count_q;
        if (inc_i & ~dec_ok)
            count_d = count_q + 1'b1;
        else if (~inc_i & dec_ok)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CBITS'(MAXOUT));
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/wb_sram_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone SRAM slave between masters A and B.
// The owner keeps the slave for its whole cyc; acks left over after cyc drops are drained.
module wb_sram_arbiter
    import wb_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SBITS  = 10,
    parameter int MAXOUT = 4,
    parameter int CBITS  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             a_cyc_i,
    input  logic             a_stb_i,
    input  logic             a_we_i,
    input  logic             a_bst_i,
    input  logic [SBITS-1:0] a_adr_i,
    input  logic [WIDTH-1:0] a_dat_i,
    output logic             a_stall_o,
    output logic             a_ack_o,
    output logic [WIDTH-1:0] a_dat_o,
    input  logic             b_cyc_i,
    input  logic             b_stb_i,
    input  logic             b_we_i,
    input  logic             b_bst_i,
    input  logic [SBITS-1:0] b_adr_i,
    input  logic [WIDTH-1:0] b_dat_i,
    output logic             b_stall_o,
    output logic             b_ack_o,
    output logic [WIDTH-1:0] b_dat_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic             s_bst_o,
    output logic [SBITS-1:0] s_adr_o,
    output logic [WIDTH-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic [WIDTH-1:0] s_dat_i
);

    state_e state_q, state_d;
    mid_e   owner_q, owner_d;
    mid_e   last_q,  last_d;

    logic             a_req, b_req, busy, own_sel_b;
    logic             own_cyc, own_stb, own_stall, issue, drained;
    logic [CBITS-1:0] count;
    logic             full, zero;

    assign a_req     = a_cyc_i & a_stb_i;
    assign b_req     = b_cyc_i & b_stb_i;
    assign busy      = (state_q == ST_BUSY);
    assign own_sel_b = (owner_q == MID_B);

    assign own_cyc   = own_sel_b ? b_cyc_i : a_cyc_i;
    assign own_stb   = own_sel_b ? b_stb_i : a_stb_i;
    // A same-cycle ack frees a slot, so a full pipeline can still accept a new transfer.
    assign own_stall = full & ~s_ack_i;
    assign issue     = busy & own_cyc & own_stb & ~own_stall;
    assign drained   = zero | ((count == CBITS'(1)) & s_ack_i);

    wb_outstanding_ctr #(
        .MAXOUT (MAXOUT),
        .CBITS  (CBITS)
    ) u_ctr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (issue),
        .dec_i   (s_ack_i),
        .count_o (count),
        .full_o  (full),
        .zero_o  (zero)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (a_req | b_req) begin
                    state_d = ST_BUSY;
                    if (a_req & b_req)
                        owner_d = (last_q == MID_A) ? MID_B : MID_A;
                    else
                        owner_d = a_req ? MID_A : MID_B;
                end
            end
            ST_BUSY: begin
                if (!own_cyc) begin
                    state_d = drained ? ST_IDLE : ST_DRAIN;
                    if (drained)
                        last_d = owner_q;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= MID_A;
            last_q  <= MID_B;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign s_cyc_o   = (state_q != ST_IDLE);
    assign s_stb_o   = issue;
    assign s_we_o    = own_sel_b ? b_we_i  : a_we_i;
    assign s_bst_o   = own_sel_b ? b_bst_i : a_bst_i;
    assign s_adr_o   = own_sel_b ? b_adr_i : a_adr_i;
    assign s_dat_o   = own_sel_b ? b_dat_i : a_dat_i;

    assign a_stall_o = ~(busy & ~own_sel_b) | own_stall;
    assign b_stall_o = ~(busy &  own_sel_b) | own_stall;
    assign a_ack_o   = s_ack_i & busy & ~own_sel_b;
    assign b_ack_o   = s_ack_i & busy &  own_sel_b;
    assign a_dat_o   = s_dat_i;
    assign b_dat_o   = s_dat_i;

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Randomized bench for wb_sram_arbiter: two bus-master drivers, a delayed-ack SRAM slave and
// a transaction-level model (owner session + in-flight transfer queue) checked every cycle.
module tb_wb_sram_arbiter;

    localparam int WIDTH  = 32;
    localparam int SBITS  = 10;
    localparam int MAXOUT = 4;
    localparam int CBITS  = 3;
    localparam int LIMIT  = 1000;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       m_cyc = '0, m_stb = '0, m_we = '0, m_bst = '0;
    logic [SBITS-1:0] m_adr  [2];
    logic [WIDTH-1:0] m_wdat [2];

    logic             a_stall, b_stall, a_ack, b_ack;
    logic [WIDTH-1:0] a_rdat, b_rdat;
    logic             s_cyc_o, s_stb_o, s_we_o, s_bst_o;
    logic [SBITS-1:0] s_adr_o;
    logic [WIDTH-1:0] s_dat_o;
    logic             s_ack_i = 1'b0;
    logic [WIDTH-1:0] s_dat_i = '0;

    wb_sram_arbiter #(.WIDTH(WIDTH), .SBITS(SBITS), .MAXOUT(MAXOUT), .CBITS(CBITS)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .a_cyc_i(m_cyc[0]), .a_stb_i(m_stb[0]), .a_we_i(m_we[0]), .a_bst_i(m_bst[0]),
        .a_adr_i(m_adr[0]), .a_dat_i(m_wdat[0]),
        .a_stall_o(a_stall), .a_ack_o(a_ack), .a_dat_o(a_rdat),
        .b_cyc_i(m_cyc[1]), .b_stb_i(m_stb[1]), .b_we_i(m_we[1]), .b_bst_i(m_bst[1]),
        .b_adr_i(m_adr[1]), .b_dat_i(m_wdat[1]),
        .b_stall_o(b_stall), .b_ack_o(b_ack), .b_dat_o(b_rdat),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_bst_o(s_bst_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- slave: in-order acks, each dly cycles after issue
    typedef struct { int due; logic [WIDTH-1:0] dat; } sl_t;
    sl_t              sq[$];
    logic [WIDTH-1:0] smem [1<<SBITS];
    int               cyc_n = 0, dly = 1, last_due = 0;

    initial begin
        forever begin
            @(posedge clk); #1;
            cyc_n++;
            if (!rst_ni) begin
                sq.delete();
                s_ack_i = 1'b0;
            end else if (sq.size() != 0 && sq[0].due <= cyc_n) begin
                s_ack_i = 1'b1;
                s_dat_i = sq[0].dat;
                void'(sq.pop_front());
            end else begin
                s_ack_i = 1'b0;
                s_dat_i = $urandom;
            end
        end
    end

    always @(negedge clk) begin
        sl_t t;
        if (rst_ni && s_cyc_o && s_stb_o) begin
            t.due = (cyc_n + dly > last_due + 1) ? cyc_n + dly : last_due + 1;
            last_due = t.due;
            if (s_we_o) smem[s_adr_o] = s_dat_o;
            t.dat = smem[s_adr_o];
            sq.push_back(t);
        end
    end

    // ---------------- reference model: who owns the bus and what is in flight
    typedef struct { bit who; bit live; bit we; logic [WIDTH-1:0] dat; } ent_t;
    ent_t             q[$];
    logic [WIDTH-1:0] ref_mem [1<<SBITS];
    int  ph = 0;          // 0 free, 1 owner session, 2 waiting for leftover acks
    bit  own = 1'b0, last = 1'b1;
    int  glog[$];
    int  n_stb = 0, nbacks = 0, absorbed = 0, max_out = 0, n_ostall = 0;

    always @(negedge clk) begin
        logic [1:0] req, st, ack, exp_ack;
        ent_t e, ne;
        bit   got, exp_st, iss;
        int   outs;
        if (!rst_ni) begin
            q.delete();
            ph = 0; own = 1'b0; last = 1'b1;
        end else begin
            req = m_cyc & m_stb;
            st  = {b_stall, a_stall};
            ack = {b_ack, a_ack};
            outs = q.size();
            got = 1'b0;
            e = '{who: 1'b0, live: 1'b0, we: 1'b0, dat: '0};
            if (s_ack_i) begin
                chk("ack_pending", outs != 0, 1);
                if (outs != 0) begin e = q.pop_front(); got = 1'b1; end
            end
            exp_ack = '0;
            if (got) begin
                if (e.live) exp_ack[e.who] = 1'b1;
                else absorbed++;
            end
            chk("a_ack", ack[0], exp_ack[0]);
            chk("b_ack", ack[1], exp_ack[1]);
            if (got && e.live && !e.we)
                chk(e.who ? "b_dat" : "a_dat", e.who ? b_rdat : a_rdat, e.dat);
            if (ack[1]) nbacks++;
            case (ph)
                0: begin
                    chk("idle_cyc", s_cyc_o, 0);
                    chk("idle_stb", s_stb_o, 0);
                    chk("idle_stall", st, 2'b11);
                    if (req != 2'b00) begin
                        own = (req == 2'b11) ? ~last : req[1];
                        ph = 1;
                        glog.push_back(int'(own));
                    end
                end
                1: begin
                    exp_st = (outs == MAXOUT) && !s_ack_i;
                    chk("busy_cyc", s_cyc_o, 1);
                    chk("own_stall", st[own], exp_st);
                    chk("other_stall", st[~own], 1);
                    if (st[own] && req[own]) n_ostall++;
                    iss = req[own] && !exp_st;
                    chk("s_stb", s_stb_o, iss);
                    if (iss) begin
                        chk("s_adr", s_adr_o, m_adr[own]);
                        chk("s_we", s_we_o, m_we[own]);
                        chk("s_bst", s_bst_o, m_bst[own]);
                        if (m_we[own]) begin
                            chk("s_wdat", s_dat_o, m_wdat[own]);
                            ref_mem[m_adr[own]] = m_wdat[own];
                        end
                        ne.who = own; ne.live = 1'b1; ne.we = m_we[own];
                        ne.dat = ref_mem[m_adr[own]];
                        q.push_back(ne);
                        n_stb++;
                    end
                    if (q.size() > max_out) max_out = q.size();
                    if (!m_cyc[own]) begin
                        last = own;
                        foreach (q[i]) q[i].live = 1'b0;
                        ph = (q.size() == 0) ? 0 : 2;
                    end
                end
                default: begin
                    chk("drain_cyc", s_cyc_o, 1);
                    chk("drain_stb", s_stb_o, 0);
                    chk("drain_stall", st, 2'b11);
                    if (q.size() == 0) ph = 0;
                end
            endcase
        end
    end

    // ---------------- masters
    bit               op_we  [2][32];
    logic [SBITS-1:0] op_adr [2][32];
    logic [WIDTH-1:0] op_dat [2][32];
    logic [WIDTH-1:0] rdata  [2][32];
    int               nacks[2], nst[2];

    task automatic drive_op(input int id, input int k);
        m_stb[id]  = 1'b1;
        m_we[id]   = op_we[id][k];
        m_adr[id]  = op_adr[id][k];
        m_wdat[id] = op_dat[id][k];
    endtask

    task automatic run_master(input int id, input int n, input bit drop_early);
        int issued, acked, guard;
        issued = 0; acked = 0; guard = 0; nst[id] = 0;
        @(posedge clk); #1;
        m_cyc[id] = 1'b1;
        m_bst[id] = (n > 1);
        drive_op(id, 0);
        while (guard < LIMIT) begin
            @(negedge clk);
            guard++;
            if (!rst_ni) break;
            if (id == 0 ? a_ack : b_ack) begin
                if (acked < 32) rdata[id][acked] = (id == 0) ? a_rdat : b_rdat;
                acked++;
            end
            if (m_stb[id]) begin
                if (id == 0 ? a_stall : b_stall) nst[id]++;
                else issued++;
            end
            @(posedge clk); #1;
            if (issued < n) drive_op(id, issued);
            else begin
                m_stb[id] = 1'b0;
                if (drop_early || acked >= n) break;
            end
        end
        chk("master_bound", guard < LIMIT, 1);
        m_cyc[id] = 1'b0; m_stb[id] = 1'b0; m_bst[id] = 1'b0;
        nacks[id] = acked;
    endtask

    task automatic check_reset_outs();
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_a_stall", a_stall, 1);
        chk("rst_b_stall", b_stall, 1);
        chk("rst_a_ack", a_ack, 0);
        chk("rst_b_ack", b_ack, 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1 check_reset_outs();
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;
    endtask

    task automatic rand_ops(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            op_we[id][i]  = $urandom_range(0, 1);
            op_adr[id][i] = SBITS'($urandom_range(0, 15));
            op_dat[id][i] = $urandom;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] wd [8];
        int na, nb;
        bit da, db, act_a, act_b;
        for (int i = 0; i < (1 << SBITS); i++) begin smem[i] = '0; ref_mem[i] = '0; end
        for (int k = 0; k < 2; k++) begin m_adr[k] = '0; m_wdat[k] = '0; end

        #12 check_reset_outs();
        #1 rst_ni = 1'b1;

        // single A burst, then read back from B
        dly = 1;
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            op_we[0][i] = 1'b1; op_adr[0][i] = SBITS'(i); op_dat[0][i] = wd[i];
            op_we[1][i] = 1'b0; op_adr[1][i] = SBITS'(i); op_dat[1][i] = '0;
        end
        n_stb = 0; nbacks = 0;
        run_master(0, 8, 1'b0);
        chk("t1_stb_pulses", n_stb, 8);
        chk("t1_a_acks", nacks[0], 8);
        chk("t1_b_acks", nbacks, 0);
        chk("t1_a_stalls", nst[0], 1);
        run_master(1, 8, 1'b0);
        for (int i = 0; i < 8; i++) chk("t1_readback", rdata[1][i], wd[i]);

        // simultaneous requests after reset, then round-robin
        do_reset();
        rand_ops(0, 4); rand_ops(1, 4);
        glog.delete();
        fork
            run_master(0, 4, 1'b0);
            run_master(1, 4, 1'b0);
        join
        fork
            run_master(0, 4, 1'b0);
            run_master(1, 4, 1'b0);
        join
        chk("t2_grants", glog.size(), 4);
        if (glog.size() >= 3) begin
            chk("t2_first", glog[0], 0);
            chk("t2_second", glog[1], 1);
            chk("t2_third", glog[2], 0);
        end

        // outstanding limit with slow acks
        dly = 6;
        for (int i = 0; i < 8; i++) begin op_we[0][i] = 1'b0; op_adr[0][i] = SBITS'(i); end
        max_out = 0; n_ostall = 0;
        run_master(0, 8, 1'b0);
        chk("t3_max_out", max_out, MAXOUT);
        chk("t3_stalled", n_ostall > 0, 1);
        chk("t3_a_acks", nacks[0], 8);

        // A drops cyc with 3 reads pending while B waits
        dly = 4; absorbed = 0;
        for (int i = 0; i < 3; i++) begin op_we[0][i] = 1'b0; op_adr[0][i] = SBITS'(i); end
        rand_ops(1, 2);
        fork
            run_master(0, 3, 1'b1);
            begin repeat (2) @(posedge clk); #1; run_master(1, 2, 1'b0); end
        join
        chk("t4_a_acks", nacks[0], 0);
        chk("t4_absorbed", absorbed, 3);
        chk("t4_b_acks", nacks[1], 2);

        // steady stream: one in flight, no stalls
        dly = 1; max_out = 0; n_ostall = 0;
        for (int i = 0; i < 16; i++) begin
            op_we[0][i] = 1'b1; op_adr[0][i] = SBITS'(32 + i); op_dat[0][i] = $urandom;
        end
        run_master(0, 16, 1'b0);
        chk("t5_max_out", max_out, 1);
        chk("t5_no_stall", n_ostall, 0);
        chk("t5_a_acks", nacks[0], 16);

        // asynchronous reset in the middle of B's burst
        rand_ops(1, 16);
        fork
            run_master(1, 16, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #3 rst_ni = 1'b0;
                #1 check_reset_outs();
                repeat (2) @(posedge clk);
                #2 rst_ni = 1'b1;
            end
        join
        rand_ops(0, 2); rand_ops(1, 2);
        glog.delete();
        fork
            run_master(0, 2, 1'b0);
            run_master(1, 2, 1'b0);
        join
        chk("t6_after_rst", (glog.size() > 0) ? glog[0] : -1, 0);

        // random traffic against the model
        for (int r = 0; r < 20; r++) begin
            dly = $urandom_range(1, 6);
            na = $urandom_range(1, 8); nb = $urandom_range(1, 8);
            rand_ops(0, na); rand_ops(1, nb);
            da = ($urandom_range(0, 7) == 0); db = ($urandom_range(0, 7) == 0);
            act_a = ($urandom_range(0, 3) != 0); act_b = ($urandom_range(0, 3) != 0);
            fork
                begin if (act_a) run_master(0, na, da); end
                begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    if (act_b) run_master(1, nb, db);
                end
            join
        end
        repeat (12) @(posedge clk);
        chk("end_quiet", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
